// File: rtl/mux_scan_ctrl_pkg.sv
// Shared types and sizes for the channel-mux scan sequencer.
// State encodings and channel/data widths used by all scan files.
package mux_scan_ctrl_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } state_t;

  localparam int NUM_CH = 4;
  localparam int CH_W   = 2;
  localparam int DATA_W = 2;

endpackage

// File: rtl/mux_scan_next_ch.sv
// Rotating priority pick: first enabled channel after cur, wrapping.
// Ports: cur, mask in; nxt (cur when mask is empty), any (mask != 0) out.
module mux_scan_next_ch
  import mux_scan_ctrl_pkg::*;
(
  input  logic [CH_W-1:0]   cur,
  input  logic [NUM_CH-1:0] mask,
  output logic [CH_W-1:0]   nxt,
  output logic              any
);

  logic [2*NUM_CH-1:0] dbl;
  logic [NUM_CH-1:0]   rot;
  logic [CH_W-1:0]     off;
  logic [2:0]          sh;

  // rot[k] is the enable of channel cur+1+k
  assign dbl = {mask, mask};
  assign sh  = {1'b0, cur} + 3'd1;
  assign rot = dbl[sh +: NUM_CH];
  assign any = |mask;

  always_comb begin
    off = '0;
    priority case (1'b1)
      rot[0]:  off = 2'd0;
      rot[1]:  off = 2'd1;
      rot[2]:  off = 2'd2;
      rot[3]:  off = 2'd3;
      default: off = 2'd3;
    endcase
  end

  // off=3 lands back on cur, covering the empty-mask case
  assign nxt = cur + CH_W'(1) + off;

endmodule

// File: rtl/mux_scan_ctrl.sv
// Scans a 4:1 2-bit mux: drives S1/S0, captures data_in after DWELL clocks.
// Ports: start/stop/ch_mask/data_in in; S1,S0,busy,sample_*,ch_data out.
// Build option SCAN_CHANGE_DETECT_EN adds the change_flag output.
module mux_scan_ctrl
  import mux_scan_ctrl_pkg::*;
#(
  parameter int DWELL = 2,
  parameter int CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     stop,
  input  logic [NUM_CH-1:0]        ch_mask,
  input  logic [DATA_W-1:0]        data_in,
  output logic                     S1,
  output logic                     S0,
  output logic                     busy,
  output logic                     sample_valid,
  output logic [CH_W-1:0]          sample_ch,
  output logic [DATA_W-1:0]        sample_data,
  output logic [NUM_CH*DATA_W-1:0] ch_data
`ifdef SCAN_CHANGE_DETECT_EN
  ,
  output logic                     change_flag
`endif
);

  state_t                    state, state_d;
  logic [CH_W-1:0]           sel, sel_d;
  logic [CNT_W-1:0]          cnt, cnt_d;
  logic                      stop_q, stop_d;
  logic                      sv_d;
  logic [CH_W-1:0]           sch_d;
  logic [DATA_W-1:0]         sdat_d;
  logic [NUM_CH*DATA_W-1:0]  chd_d;
  logic                      cf_d;
  logic [CH_W-1:0]           pick_cur;
  logic [CH_W-1:0]           pick;
  logic                      pick_any;
  logic                      cap;
  logic [DATA_W-1:0]         old_d;

  // From cur=3 the rotation starts at channel 0: lowest enabled
  assign pick_cur = (state == ST_SCAN) ? sel : CH_W'(3);

  mux_scan_next_ch u_next (
    .cur  (pick_cur),
    .mask (ch_mask),
    .nxt  (pick),
    .any  (pick_any)
  );

  assign cap   = (cnt == CNT_W'(DWELL - 1));
  assign old_d = ch_data[{sel, 1'b0} +: DATA_W];

  always_comb begin
    state_d = state;
    sel_d   = sel;
    cnt_d   = cnt;
    stop_d  = stop_q;
    sv_d    = 1'b0;
    sch_d   = sample_ch;
    sdat_d  = sample_data;
    chd_d   = ch_data;
    cf_d    = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (start && !stop && pick_any) begin
          state_d = ST_SCAN;
          sel_d   = pick;
          cnt_d   = '0;
        end
      end
      ST_SCAN: begin
        stop_d = stop_q | stop;
        if (!cap) begin
          cnt_d = cnt + CNT_W'(1);
        end else begin
          chd_d[{sel, 1'b0} +: DATA_W] = data_in;
          sv_d   = 1'b1;
          sch_d  = sel;
          sdat_d = data_in;
          cf_d   = (data_in != old_d);
          cnt_d  = '0;
          if (stop_d || !pick_any) begin
            state_d = ST_IDLE;
            stop_d  = 1'b0;
          end else begin
            sel_d = pick;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      sel          <= '0;
      cnt          <= '0;
      stop_q       <= 1'b0;
      sample_valid <= 1'b0;
      sample_ch    <= '0;
      sample_data  <= '0;
      ch_data      <= '0;
    end else begin
      state        <= state_d;
      sel          <= sel_d;
      cnt          <= cnt_d;
      stop_q       <= stop_d;
      sample_valid <= sv_d;
      sample_ch    <= sch_d;
      sample_data  <= sdat_d;
      ch_data      <= chd_d;
    end
  end

`ifdef SCAN_CHANGE_DETECT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) change_flag <= 1'b0;
    else        change_flag <= cf_d;
  end
`else
  logic unused_cf;
  assign unused_cf = cf_d;
`endif

  assign busy = (state == ST_SCAN);
  assign S1   = sel[1];
  assign S0   = sel[0];

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Randomized and directed bench for mux_scan_ctrl against a channel-level model.
// Build option SCAN_CHANGE_DETECT_EN also checks change_flag.
module tb_mux_scan_ctrl;

  localparam int DW = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic [3:0] ch_mask = 4'd0;
  logic [1:0] data_in = 2'd0;
  logic       S1, S0, busy, sample_valid;
  logic [1:0] sample_ch, sample_data;
  logic [7:0] ch_data;
  logic       cf_obs;
`ifdef SCAN_CHANGE_DETECT_EN
  logic       change_flag;
  assign cf_obs = change_flag;
`else
  assign cf_obs = 1'b0;
`endif

  mux_scan_ctrl #(.DWELL(DW), .CNT_W(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .stop         (stop),
    .ch_mask      (ch_mask),
    .data_in      (data_in),
    .S1           (S1),
    .S0           (S0),
    .busy         (busy),
    .sample_valid (sample_valid),
    .sample_ch    (sample_ch),
    .sample_data  (sample_data),
    .ch_data      (ch_data)
`ifdef SCAN_CHANGE_DETECT_EN
    ,
    .change_flag  (change_flag)
`endif
  );

  always #5 clk = ~clk;

  int n_err = 0;
  int n_chk = 0;

  // channel-level model
  bit       m_busy;
  int       m_sel;
  int       m_age;
  bit       m_stop;
  bit       m_sv;
  int       m_sch;
  int       m_sdat;
  int       m_chd [4];
  bit       m_cf;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int first_after(input int cur, input logic [3:0] m);
    for (int k = 1; k <= 4; k++)
      if (m[(cur + k) % 4]) return (cur + k) % 4;
    return cur;
  endfunction

  task automatic model_reset();
    m_busy = 0; m_sel = 0; m_age = 0; m_stop = 0;
    m_sv = 0; m_sch = 0; m_sdat = 0; m_cf = 0;
    for (int i = 0; i < 4; i++) m_chd[i] = 0;
  endtask

  task automatic model_edge();
    m_sv = 0;
    m_cf = 0;
    if (!m_busy) begin
      if (start && !stop && ch_mask != 0) begin
        m_busy = 1;
        m_sel  = first_after(3, ch_mask);
        m_age  = 0;
      end
    end else begin
      if (stop) m_stop = 1;
      if (m_age < DW - 1) begin
        m_age++;
      end else begin
        m_cf   = (int'(data_in) != m_chd[m_sel]);
        m_chd[m_sel] = int'(data_in);
        m_sv   = 1;
        m_sch  = m_sel;
        m_sdat = int'(data_in);
        m_age  = 0;
        if (m_stop || ch_mask == 0) begin
          m_busy = 0;
          m_stop = 0;
        end else begin
          m_sel = first_after(m_sel, ch_mask);
        end
      end
    end
  endtask

  task automatic check_all(input string ph);
    int exp_chd;
    exp_chd = 0;
    for (int i = 0; i < 4; i++) exp_chd |= m_chd[i] << (2 * i);
    chk({ph, ".busy"}, int'(busy), int'(m_busy));
    chk({ph, ".sel"}, int'({S1, S0}), m_sel);
    chk({ph, ".sv"}, int'(sample_valid), int'(m_sv));
    chk({ph, ".sch"}, int'(sample_ch), m_sch);
    chk({ph, ".sdat"}, int'(sample_data), m_sdat);
    chk({ph, ".chd"}, int'(ch_data), exp_chd);
`ifdef SCAN_CHANGE_DETECT_EN
    chk({ph, ".cf"}, int'(cf_obs), int'(m_cf));
`endif
  endtask

  task automatic step(input string ph);
    @(posedge clk);
    model_edge();
    #1;
    check_all(ph);
  endtask

  // async reset asserted between edges, checked before any clock
  task automatic async_reset(input string ph);
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all(ph);
    chk({ph, ".all0"}, int'({S1, S0, busy, sample_valid, sample_ch,
                             sample_data, ch_data, cf_obs}), 0);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int cnt;
    int caps;
    int exp_ch;
    logic [1:0] cfv [3];
    logic [1:0] dv [3];
    model_reset();
    #12;
    check_all("reset");
    rst_n = 1'b1;
    step("idle0");

    // full mask, data follows sel+1
    ch_mask = 4'b1111;
    start = 1'b1;
    data_in = 2'(m_sel + 1);
    step("t1");
    start = 1'b0;
    for (int i = 0; i < 4 * DW; i++) begin
      data_in = 2'(m_sel + 1);
      step("t1");
    end
    chk("t1.chd", int'(ch_data), 8'b00_11_10_01);
    chk("t1.sel", int'({S1, S0}), 0);

    // stop mid-dwell on channel 2
    cnt = 0;
    while (!(m_busy && m_sel == 2 && m_age == 0) && cnt < 20) begin
      data_in = 2'($urandom);
      step("t2w");
      cnt++;
    end
    chk("t2.wait", int'(cnt < 20), 1);
    stop = 1'b1;
    step("t2a");
    stop = 1'b0;
    for (int i = 0; i < DW - 1; i++) step("t2b");
    chk("t2.busy", int'(busy), 0);
    chk("t2.sv", int'(sample_valid), 1);
    chk("t2.sch", int'(sample_ch), 2);
    chk("t2.sel", int'({S1, S0}), 2);
    step("t2c");

    // start with empty mask, start with stop
    ch_mask = 4'b0000;
    start = 1'b1;
    for (int i = 0; i < 3; i++) step("t3");
    chk("t3.busy", int'(busy), 0);
    ch_mask = 4'b0100;
    stop = 1'b1;
    step("t3s");
    chk("t3s.busy", int'(busy), 0);
    stop = 1'b0;
    start = 1'b0;

    async_reset("rst1");

    // sparse mask 1010: channels 1,3 alternate
    ch_mask = 4'b1010;
    start = 1'b1;
    step("t4");
    start = 1'b0;
    caps = 0;
    exp_ch = 1;
    for (int i = 0; i < 6 * DW; i++) begin
      data_in = 2'($urandom_range(1, 3));
      step("t4");
      if (sample_valid) begin
        chk("t4.sch", int'(sample_ch), exp_ch);
        exp_ch = (exp_ch == 1) ? 3 : 1;
        caps++;
      end
    end
    chk("t4.caps", caps, 6);
    chk("t4.ch02", int'({ch_data[5:4], ch_data[1:0]}), 0);

    // mask drops to 0 mid-dwell
    ch_mask = 4'b0000;
    for (int i = 0; i < DW + 1; i++) step("t5");
    chk("t5.busy", int'(busy), 0);

    // reset mid-scan
    ch_mask = 4'b1111;
    start = 1'b1;
    step("t6");
    start = 1'b0;
    step("t6");
    async_reset("rst2");
    for (int i = 0; i < 5; i++) step("t6i");
    chk("t6.idle", int'(busy), 0);

    // change detect sequence on channel 0
    async_reset("rst3");
    ch_mask = 4'b0001;
    start = 1'b1;
    step("t7");
    start = 1'b0;
    dv[0] = 2'b01; dv[1] = 2'b01; dv[2] = 2'b10;
    cfv[0] = 2'd1; cfv[1] = 2'd0; cfv[2] = 2'd1;
    for (int c = 0; c < 3; c++) begin
      data_in = dv[c];
      cnt = 0;
      do begin
        step("t7");
        cnt++;
      end while (!sample_valid && cnt < 10);
      chk("t7.wait", int'(cnt < 10), 1);
      chk("t7.sdat", int'(sample_data), int'(dv[c]));
`ifdef SCAN_CHANGE_DETECT_EN
      chk("t7.cf", int'(cf_obs), int'(cfv[c]));
`endif
    end

    // random traffic
    for (int i = 0; i < 600; i++) begin
      start = ($urandom % 4) == 0;
      stop = ($urandom % 12) == 0;
      if (($urandom % 10) == 0) ch_mask = 4'($urandom);
      data_in = 2'($urandom);
      if (($urandom % 150) == 0) async_reset("rnd_rst");
      else step("rnd");
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/mux_scan_ctrl.md
Name: mux_scan_ctrl

Overview:
- Sequencer that sits around the 2-bit 4:1 channel mux in the embedded datapath.
- Upstream, it drives the mux selects S1/S0 to step through enabled channels.
- Downstream, it captures the mux's 2-bit output after a settle/dwell period and holds the last value per channel.
- Gives software/top-level a scanned, registered view of four 2-bit inputs, with a one-cycle sample strobe.

Parameters:
- DWELL, 2, clocks each channel is selected before capture; legal range 1..255.
- CNT_W, 8, dwell counter width; must satisfy DWELL-1 <= 2^CNT_W-1.

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  level; sampled in IDLE, begins scanning.
- stop  input  1  level; sampled in SCAN, ends scanning after the current capture.
- ch_mask  input  4  bit i = channel i enabled (i = {S1,S0}).
- data_in  input  2  mux output {Out1_b, Out0_b}.
- S1  output  1  mux select MSB (registered).
- S0  output  1  mux select LSB (registered).
- busy  output  1  high in SCAN.
- sample_valid  output  1  one-cycle pulse per capture.
- sample_ch  output  2  channel of the latest capture.
- sample_data  output  2  data of the latest capture.
- ch_data  output  8  per-channel hold registers; [2i+1:2i] = channel i.

Behaviour:
- Clock and reset: one clock (clk); reset rst_n is asynchronous, active-low. All state is reset by rst_n low, independent of clk.
- Reset values: state=IDLE; S1=S0=0; busy=0; sample_valid=0; sample_ch=0; sample_data=0; ch_data=0; dwell count=0; stop latch=0.
- States: IDLE and SCAN.
- IDLE → SCAN at an edge where start=1, stop=0 and ch_mask!=0.
  - sel (S1,S0) loads the lowest-index enabled channel; count=0.
- IDLE with start=1 and ch_mask=0: stays IDLE. start=1 with stop=1 in IDLE: stays IDLE.
- SCAN, each edge:
  - If count<DWELL-1: count++, sel held.
  - If count==DWELL-1 (capture edge):
    - Load data_in into ch_data[sel], sample_data and sample_ch=sel.
    - sample_valid=1 for the following cycle only.
    - count=0.
    - sel advances to the next enabled channel: first set bit of ch_mask at sel+1, sel+2, sel+3, sel+4 (mod 4, wraps 3→0).
    - If only the current channel is enabled, sel stays.
- Latency:
  - sample_valid rises DWELL cycles after the start edge.
  - While scanning, one capture every DWELL cycles; no gap cycles.
- stop:
  - Any stop=1 seen in SCAN sets a sticky stop latch.
  - On the next capture edge, the capture still completes, then state=IDLE, busy=0, latch cleared, sel holds the captured channel (no advance).
  - stop is ignored in IDLE.
- ch_mask changes mid-scan:
  - Affect only the next-channel choice at the capture edge; the current dwell is never aborted.
  - If ch_mask==0 at a capture edge: capture completes, then go to IDLE as if stopped.
- DWELL=1: capture on every edge in SCAN, and sample_valid stays high continuously.
- Reset mid-scan: immediate return to reset values; no partial capture.

Optional Feature:
- Macro SCAN_CHANGE_DETECT_EN.
- When defined:
  - Adds output change_flag (1 bit, resets to 0).
  - change_flag pulses high together with sample_valid when the captured data_in differs from the previous ch_data[sel].
  - The very first capture of a channel after reset counts as a change only if nonzero.
- When undefined: the port and its logic are absent, and all other behaviour is identical.

Decomposition:
- Shared include/package:
  - state encodings ST_IDLE=1'b0, ST_SCAN=1'b1;
  - NUM_CH=4, CH_W=2, DATA_W=2.
- One sub-module: mux_scan_next_ch, a combinational rotating priority pick.
  - Inputs: cur[1:0], mask[3:0].
  - Outputs: nxt[1:0], any (mask!=0).

Test Plan:
- Reset, then start=1 one cycle, mask=4'b1111, DWELL=2, data_in follows sel ({S1,S0}+1 mod 4) → S1S0 sequence 00,01,10,11,00 every 2 clocks; sample_valid every 2nd cycle; ch_data=8'b00_11_10_01.
- mask=4'b1010, DWELL=3 → sel visits 01,11,01,...; sample_ch alternates 1,3; ch_data bits for channels 0 and 2 stay 0.
- Scanning, pulse stop=1 mid-dwell on channel 2 → capture of channel 2 still occurs; busy falls in the same cycle sample_valid rises; S1S0 remains 10.
- start=1 with mask=0 → busy stays 0, no sample_valid. Then mask goes to 0 mid-scan → current capture completes, then IDLE.
- Assert rst_n=0 asynchronously between clock edges mid-scan → all outputs 0 immediately. After release, no activity until start.
- With SCAN_CHANGE_DETECT_EN, mask=4'b0001, data_in 2'b01,2'b01,2'b10 on successive captures → change_flag 1,0,1.
